// File: rtl/pb_fb_scanout_fetch.sv
// Frame-buffer scan-out prefetcher: issues sequential burst reads over one frame into a
// local fall-through FIFO and drains it as a valid/ready pixel stream.
module pb_fb_scanout_fetch #(
    parameter int DW        = 16,
    parameter int CMD_AW    = 23,
    parameter int BURST_LEN = 32,
    parameter int FIFO_AW   = 6,
    parameter int FB_BASE   = 0,
    parameter int FB_BURSTS = 9600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              cmd_bst_rd_req,
    input  logic              cmd_bst_rd_ack,
    output logic [CMD_AW-1:0] cmd_addr,
    input  logic [DW-1:0]     rd_data,
    input  logic              rd_vld,
    output logic [DW-1:0]     pix_data,
    output logic              pix_vld,
    input  logic              pix_rdy,
    output logic              underflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int IW    = $clog2(FB_BURSTS + 1);
    localparam int BW    = $clog2(BURST_LEN + 1);
    localparam logic [CW:0]       ROOM_MAX = (CW+1)'(DEPTH - BURST_LEN);
    localparam logic [CMD_AW-1:0] ADDR_STEP = CMD_AW'(BURST_LEN / 2);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_END} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [BW-1:0]   wcnt, wcnt_nxt;
    logic            flush_pend, flush_pend_nxt;
    logic            flush, wr_en, rd_en;
    logic [CW-1:0]   wr_ptr, rd_ptr, count, reserved;
    logic [CW:0]     used;
    logic            room;
    logic [DW-1:0]   mem [DEPTH];

    // Reservation shrinks as burst words land, so count + reserved never double-counts.
    assign count    = wr_ptr - rd_ptr;
    assign reserved = (state == S_IDLE) ? '0 : CW'(BURST_LEN) - CW'(wcnt);
    assign used     = {1'b0, count} + {1'b0, reserved};
    assign room     = (used <= ROOM_MAX);

    assign pix_vld        = (count != '0);
    assign pix_data       = mem[rd_ptr[FIFO_AW-1:0]];
    assign rd_en          = pix_vld && pix_rdy && !frame_start;
    assign cmd_bst_rd_req = (state == S_REQ);
    assign cmd_addr       = CMD_AW'(FB_BASE) + CMD_AW'(idx) * ADDR_STEP;

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        wcnt_nxt       = wcnt;
        flush_pend_nxt = flush_pend;
        flush          = frame_start;
        wr_en          = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    idx_nxt = '0;
                end else if (room && idx < IW'(FB_BURSTS)) begin
                    state_nxt = S_REQ;
                    wcnt_nxt  = '0;
                end
            end
            S_REQ: begin
                if (cmd_bst_rd_ack) begin
                    state_nxt = S_DATA;
                    if (frame_start) flush_pend_nxt = 1'b1;
                end else if (frame_start) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (frame_start) flush_pend_nxt = 1'b1;
                if (rd_vld) begin
                    wr_en    = !flush_pend && !frame_start;
                    wcnt_nxt = wcnt + BW'(1);
                    if (wcnt == BW'(BURST_LEN - 1)) state_nxt = S_END;
                end
            end
            S_END: begin
                if (frame_start) flush_pend_nxt = 1'b1;
                // Leaving only after ack drops gives the controller its idle cycle.
                if (!cmd_bst_rd_ack) begin
                    state_nxt      = S_IDLE;
                    flush_pend_nxt = 1'b0;
                    if (flush_pend || frame_start) begin
                        idx_nxt = '0;
                        flush   = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            wcnt       <= '0;
            flush_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            wcnt       <= wcnt_nxt;
            flush_pend <= flush_pend_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + CW'(1);
                if (rd_en) rd_ptr <= rd_ptr + CW'(1);
            end
            if (frame_start)               underflow <= 1'b0;
            else if (pix_rdy && !pix_vld)  underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= rd_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && count == CW'(DEPTH)));

endmodule

// File: tb/tb_pb_fb_scanout_fetch.sv
// Bench for pb_fb_scanout_fetch: SDRAM controller model plus a frame-level reference
// (pixel n of a frame equals word n of the frame buffer).
module tb_pb_fb_scanout_fetch;

    localparam int DW     = 16;
    localparam int CMD_AW = 23;
    localparam int BL     = 32;
    localparam int NB     = 4;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fs_main = 1'b0;
    logic              fs_ctl = 1'b0;
    logic              frame_start;
    logic              req;
    logic              ack = 1'b0;
    logic [CMD_AW-1:0] cmd_addr;
    logic [DW-1:0]     rd_data = '0;
    logic              rd_vld = 1'b0;
    logic [DW-1:0]     pix_data;
    logic              pix_vld;
    logic              pix_rdy = 1'b0;
    logic              underflow;

    assign frame_start = fs_main | fs_ctl;

    pb_fb_scanout_fetch #(
        .DW(DW), .CMD_AW(CMD_AW), .BURST_LEN(BL), .FIFO_AW(6), .FB_BASE(0), .FB_BURSTS(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .cmd_bst_rd_req(req), .cmd_bst_rd_ack(ack), .cmd_addr(cmd_addr),
        .rd_data(rd_data), .rd_vld(rd_vld),
        .pix_data(pix_data), .pix_vld(pix_vld), .pix_rdy(pix_rdy), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Controller knobs, written only by the main sequence.
    int rand_mode = 0, lat = 5, extra = 0, gaps = 0, stall_tok = 0, fs_tok = 0;

    // Reference state, updated only by the monitor.
    int occ = 0, exp_pix = 0, exp_burst = 0, wcount = 0, total_acks = 0, fs_cnt = 0;
    logic in_burst = 1'b0, discard = 1'b0, exp_uf = 1'b0, ack_q = 1'b0;
    logic [CMD_AW-1:0] last_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        fs_main = 1'b1;
        tick();
        fs_main = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (total_acks < n && k < budget) begin tick(); k++; end
        if (total_acks < n) check("timeout_acks", total_acks, n);
    endtask

    task automatic wait_pix(input int n, input int budget);
        int k = 0;
        while (exp_pix < n && k < budget) begin tick(); k++; end
        if (exp_pix < n) check("timeout_pix", exp_pix, n);
    endtask

    // SDRAM controller model: ack after a latency, then BL words (+extras), word = address.
    initial begin : ctl
        int lat_i, n, word, ext, stall_seen, fs_seen;
        logic [CMD_AW-1:0] base;
        logic ok, fs_arm;
        stall_seen = 0;
        fs_seen    = 0;
        forever begin
            tick();
            if (rst_n && req) begin
                base  = cmd_addr;
                ok    = 1'b1;
                lat_i = (rand_mode != 0) ? int'($urandom_range(20, 1)) : lat;
                for (int i = 0; i < lat_i; i++) begin
                    tick();
                    if (!req) begin ok = 1'b0; break; end
                end
                if (ok) begin
                    ack    = 1'b1;
                    fs_arm = (fs_tok != fs_seen);
                    fs_seen = fs_tok;
                    ext    = (rand_mode != 0) ? 2 * int'($urandom_range(1, 0)) : extra;
                    if (stall_tok != stall_seen) begin
                        stall_seen = stall_tok;
                        repeat (200) tick();
                    end
                    n = 0;
                    while (n < BL + ext) begin
                        tick();
                        fs_ctl = 1'b0;
                        if (gaps != 0 && $urandom_range(3, 0) == 0) begin
                            rd_vld = 1'b0;
                        end else begin
                            rd_vld  = 1'b1;
                            word    = int'(base) * 2 + n;
                            rd_data = word[DW-1:0];
                            if (fs_arm && n == 9) fs_ctl = 1'b1;
                            n++;
                        end
                    end
                    tick();
                    fs_ctl = 1'b0;
                    rd_vld = 1'b0;
                    ack    = 1'b0;
                end
            end
        end
    end

    // Monitor: checks the state left by the last edge, then predicts the next edge.
    always @(negedge clk) begin
        if (fs_ctl) fs_cnt++;
        if (!rst_n) begin
            occ = 0; exp_pix = 0; exp_burst = 0; wcount = 0;
            in_burst = 1'b0; discard = 1'b0; exp_uf = 1'b0; ack_q = 1'b0;
        end else begin
            check("pix_vld", pix_vld, (occ > 0));
            if (pix_vld) check("pix_data", pix_data, exp_pix[DW-1:0]);
            check("underflow", underflow, exp_uf);
            if (ack && !ack_q) begin
                check("cmd_addr", cmd_addr, exp_burst * (BL / 2));
                check("burst_budget", (exp_burst < NB), 1);
                last_addr = cmd_addr;
                exp_burst++;
                total_acks++;
                in_burst = 1'b1;
                wcount   = 0;
                discard  = 1'b0;
            end
            if (!ack && ack_q) begin
                check("req_gap", req, 0);
                in_burst = 1'b0;
            end
            if (in_burst && rd_vld && wcount < BL) begin
                wcount++;
                if (!discard && !frame_start) occ++;
            end
            if (occ > DEPTH) check("occupancy", occ, DEPTH);
            if (frame_start) begin
                occ = 0; exp_pix = 0; exp_burst = 0; exp_uf = 1'b0;
                discard = in_burst;
            end else begin
                if (pix_vld && pix_rdy) begin exp_pix++; occ--; end
                if (pix_rdy && !pix_vld) exp_uf = 1'b1;
            end
            ack_q = ack;
        end
    end

    initial begin : main
        int base_acks;
        int k;
        repeat (3) tick();
        check("rst_req", req, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_vld", pix_vld, 0);
        check("rst_uf", underflow, 0);
        rst_n = 1'b1;

        // Two bursts fill the FIFO, then requests stop.
        repeat (300) tick();
        check("t1_nreq", total_acks, 2);
        check("t1_req_idle", req, 0);
        check("t1_vld", pix_vld, 1);

        // Continuous drain with a 20-cycle request latency.
        lat = 20;
        pix_rdy = 1'b1;
        wait_pix(80, 500);
        check("t2_no_uf", underflow, 0);
        wait_pix(128, 1500);
        pix_rdy = 1'b0;
        check("t2_nreq", total_acks, 4);

        // Frame exhausted: no more requests until frame_start.
        repeat (100) tick();
        check("t3_nreq_cap", total_acks, 4);
        check("t3_req_idle", req, 0);
        lat = 5;
        fs_tok++;
        pulse_fs();
        check("t3_uf_clr", underflow, 0);
        wait_acks(5, 300);
        check("t3_addr0", last_addr, 0);

        // frame_start lands on the 10th word of that burst.
        k = 0;
        while (fs_cnt < 1 && k < 300) begin tick(); k++; end
        check("t4_fs_fired", fs_cnt, 1);
        check("t4_flush_vld", pix_vld, 0);
        wait_acks(6, 300);
        check("t4_addr0", last_addr, 0);
        k = 0;
        while (!pix_vld && k < 300) begin tick(); k++; end
        check("t4_first_vld", pix_vld, 1);
        check("t4_first_pix", pix_data, 0);

        // Starved output: sticky underflow, cleared by frame_start.
        stall_tok++;
        pix_rdy = 1'b1;
        pulse_fs();
        repeat (150) tick();
        check("t5_uf_set", underflow, 1);
        repeat (300) tick();
        check("t5_uf_sticky", underflow, 1);
        pix_rdy = 1'b0;
        pulse_fs();
        check("t5_uf_clr", underflow, 0);

        // Over-long bursts: only BL words per burst are kept.
        base_acks = total_acks;
        extra = 2;
        repeat (400) tick();
        check("t6_nreq", total_acks, base_acks + 2);
        check("t6_vld", pix_vld, 1);
        extra = 0;
        pix_rdy = 1'b1;
        wait_pix(64, 400);

        // Randomized traffic against the reference.
        rand_mode = 1;
        gaps = 1;
        for (int c = 0; c < 6000; c++) begin
            pix_rdy = ($urandom_range(3, 0) != 0);
            fs_main = ($urandom_range(499, 0) == 0);
            tick();
        end
        fs_main = 1'b0;
        pix_rdy = 1'b0;
        repeat (50) tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
